// File: rtl/reg_bus_master_if.sv
// Bus bundle for reg_bus_master: command byte stream in, read-data byte
// stream out, and the register-side access bus.
//
// Handshake: on both byte streams a byte moves on a rising clock edge where
// valid and ready are both high. The producer holds data stable while valid
// is high and ready is low. Valid never waits on ready.
interface reg_bus_master_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        cmd_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] reg_address;
    logic [15:0]       reg_bytecnt;
    logic [15:0]       reg_size;
    logic [7:0]        reg_datai;
    logic [7:0]        reg_datao;
    logic              reg_read;
    logic              reg_write;
    logic              reg_addrvalid;
    logic [ADDR_W-1:0] reg_hypaddress;
    logic [15:0]       reg_hyplen;

    modport master (
        input  cmd_data, cmd_valid, rsp_ready, reg_datao, reg_hyplen,
        output cmd_ready, rsp_data, rsp_valid, reg_address, reg_bytecnt,
        output reg_size, reg_datai, reg_read, reg_write, reg_addrvalid,
        output reg_hypaddress
    );

    modport slave (
        output cmd_data, cmd_valid, rsp_ready, reg_datao, reg_hyplen,
        input  cmd_ready, rsp_data, rsp_valid, reg_address, reg_bytecnt,
        input  reg_size, reg_datai, reg_read, reg_write, reg_addrvalid,
        input  reg_hypaddress
    );
endinterface

// File: rtl/reg_bus_master.sv
// Byte-stream to register-bus bridge. A command is a header byte
// (bit7 = read, low ADDR_W bits = address), a 16-bit little-endian length,
// and for writes that many data bytes. A zero length asks the register
// file for the register's natural length via reg_hyplen.
module reg_bus_master #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    reg_bus_master_if.master bus,
    output logic             busy,
    output logic [3:0]       dbg_state
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEN0, S_LEN1, S_SETUP, S_WGET,
        S_WPULSE, S_RPULSE, S_RCAP, S_RSEND
    } state_t;

    // Watchdog counts 0..TIMEOUT-1 idle cycles; the last value means expiry.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic              is_read;
    logic [7:0]        len_lo;
    logic [15:0]       size;
    logic [15:0]       cnt;
    logic [7:0]        datai;
    logic [7:0]        rdata;
    logic [WD_W-1:0]   wdog;

    logic              cmd_take;
    logic              cmd_fire;
    logic              rsp_fire;
    logic              wd_expired;
    logic              last_byte;
    logic [15:0]       len_rx;
    logic [15:0]       eff_len;

    // Ready depends only on state so the handshake never loops through valid.
    assign cmd_take   = !reset && (state inside {S_IDLE, S_LEN0, S_LEN1, S_WGET});
    assign cmd_fire   = cmd_take && bus.cmd_valid;
    assign rsp_fire   = (state == S_RSEND) && bus.rsp_ready;
    assign wd_expired = (wdog == WD_LAST) && !cmd_fire;
    assign last_byte  = (cnt == size - 16'd1);
    assign len_rx     = {bus.cmd_data, len_lo};
    assign eff_len    = (len_rx != 16'd0) ? len_rx : bus.reg_hyplen;

    assign bus.cmd_ready      = cmd_take;
    assign bus.reg_address    = addr;
    assign bus.reg_hypaddress = addr;
    assign bus.reg_bytecnt    = cnt;
    assign bus.reg_size       = size;
    assign bus.reg_datai      = datai;
    assign bus.rsp_data       = rdata;
    assign dbg_state          = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        state_next        = state;
        busy              = 1'b0;
        bus.reg_addrvalid = 1'b0;
        bus.reg_read      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.rsp_valid     = 1'b0;
        unique case (state)
            S_IDLE:   if (cmd_fire) state_next = S_LEN0;
            S_LEN0:   if (cmd_fire) state_next = S_LEN1;
                      else if (wd_expired) state_next = S_IDLE;
            S_LEN1:   if (cmd_fire) state_next = (eff_len == 16'd0) ? S_IDLE : S_SETUP;
                      else if (wd_expired) state_next = S_IDLE;
            S_SETUP:  state_next = is_read ? S_RPULSE : S_WGET;
            S_WGET:   if (cmd_fire) state_next = S_WPULSE;
                      else if (wd_expired) state_next = S_IDLE;
            S_WPULSE: state_next = last_byte ? S_IDLE : S_WGET;
            S_RPULSE: state_next = S_RCAP;
            S_RCAP:   state_next = S_RSEND;
            S_RSEND:  if (rsp_fire) state_next = last_byte ? S_IDLE : S_RPULSE;
            default:  state_next = S_IDLE;
        endcase
        if (!reset) begin
            busy              = (state != S_IDLE);
            bus.reg_addrvalid = !(state inside {S_IDLE, S_LEN0, S_LEN1});
            bus.reg_read      = (state == S_RPULSE);
            bus.reg_write     = (state == S_WPULSE);
            bus.rsp_valid     = (state == S_RSEND);
        end
    end

    // Command latches, byte counter, read-data capture and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr    <= '0;
            is_read <= 1'b0;
            len_lo  <= 8'd0;
            size    <= 16'd0;
            cnt     <= 16'd0;
            datai   <= 8'd0;
            rdata   <= 8'd0;
            wdog    <= '0;
        end else begin
            if (state != state_next || cmd_fire) wdog <= '0;
            else if (state inside {S_LEN0, S_LEN1, S_WGET}) wdog <= wdog + WD_W'(1);

            unique case (state)
                S_IDLE:   if (cmd_fire) begin
                              addr    <= bus.cmd_data[ADDR_W-1:0];
                              is_read <= bus.cmd_data[7];
                          end
                S_LEN0:   if (cmd_fire) len_lo <= bus.cmd_data;
                S_LEN1:   if (cmd_fire) begin
                              size <= eff_len;
                              cnt  <= 16'd0;
                          end
                S_WGET:   if (cmd_fire) datai <= bus.cmd_data;
                // Counter returns to 0 after the final byte so it never shows size.
                S_WPULSE: cnt <= last_byte ? 16'd0 : cnt + 16'd1;
                S_RCAP:   rdata <= bus.reg_datao;
                S_RSEND:  if (rsp_fire) cnt <= last_byte ? 16'd0 : cnt + 16'd1;
                default:  ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: a command-level model predicts every
// register access and every response byte; a negedge monitor compares.
module tb_reg_bus_master;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [3:0] dbg_state;

    reg_bus_master_if #(.ADDR_W(ADDR_W)) bus ();

    reg_bus_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard state.
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_wr_q[$];   // {addr8, bytecnt16, data8}
    logic [23:0] exp_rd_q[$];   // {addr8, bytecnt16}
    logic [7:0]  exp_q[$];      // response bytes
    logic [7:0]  wd[$];         // write payload of the command being sent
    int rd_cyc_q[$];
    int rsp_cyc_q[$];
    int rd_seen = 0;
    int wr_seen = 0;
    int first_rsp_cyc = -1;
    int last_xfer_cyc = 0;
    logic [15:0] last_size;
    logic [31:0] last_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        checks++;
        failures++;
        $display("FAIL %s %s", name, msg);
    endtask

    // Command-level model: what accesses and bytes a command must produce.
    task automatic model_cmd(input logic [7:0] hdr, input logic [15:0] len,
                             input logic [15:0] hyplen, input int nsent);
        logic [7:0] a;
        int eff;
        a   = 8'(hdr[ADDR_W-1:0]);
        eff = (len != 16'd0) ? int'(len) : int'(hyplen);
        if (hdr[7]) begin
            for (int n = 0; n < eff; n++) begin
                exp_rd_q.push_back({a, 16'(n)});
                exp_q.push_back(8'h10 + 8'(n));
            end
        end else begin
            for (int n = 0; n < eff && n < nsent; n++)
                exp_wr_q.push_back({a, 16'(n), wd[n]});
        end
    endtask

    // Driver: offer one command byte, wait for acceptance (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        while (!bus.cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.cmd_ready) fail_now("cmd_accept", $sformatf("byte %0h not accepted in 100 cycles", b));
        @(posedge clk);
        #1;
        last_xfer_cyc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] hdr, input logic [15:0] len, input int nsent);
        send_byte(hdr);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < nsent; i++) send_byte(wd[i]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (busy) fail_now(name, "busy still 1 after 500 cycles, required 0");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.rsp_valid) fail_now(name, "rsp_valid still 0 after 100 cycles, required 1");
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.cmd_ready, bus.rsp_valid, bus.reg_read, bus.reg_write,
                     bus.reg_addrvalid, busy, bus.rsp_data, bus.reg_datai,
                     8'(bus.reg_address)}, 32'd0);
        check({name, "_cnt_size"}, {bus.reg_bytecnt, bus.reg_size}, 32'd0);
    endtask

    // Monitor, scoreboard and register responder, all away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("rd_wr_exclusive", {31'd0, bus.reg_read & bus.reg_write}, 32'd0);
            if (bus.reg_read || bus.reg_write)
                check("strobe_addrvalid", {31'd0, bus.reg_addrvalid}, 32'd1);
            if (!busy)
                check("idle_addrvalid", {31'd0, bus.reg_addrvalid}, 32'd0);
            if (bus.reg_write) begin
                wr_seen++;
                last_wr = {8'(bus.reg_address), bus.reg_bytecnt, bus.reg_datai};
                if (exp_wr_q.size() == 0) fail_now("write_event", $sformatf("unexpected write %0h", last_wr));
                else check("write_event", last_wr, exp_wr_q.pop_front());
            end
            if (bus.reg_read) begin
                rd_seen++;
                rd_cyc_q.push_back(cyc);
                last_size = bus.reg_size;
                bus.reg_datao = 8'h10 + bus.reg_bytecnt[7:0];
                if (exp_rd_q.size() == 0)
                    fail_now("read_event", $sformatf("unexpected read cnt=%0d", bus.reg_bytecnt));
                else
                    check("read_event", {8'd0, 8'(bus.reg_address), bus.reg_bytecnt}, {8'd0, exp_rd_q.pop_front()});
            end
            if (bus.rsp_valid) begin
                if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
                if (bus.rsp_ready) begin
                    rsp_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) fail_now("rsp_data", $sformatf("unexpected byte %0h", bus.rsp_data));
                    else check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic check_drained(input string name);
        check({name, "_wr_left"}, exp_wr_q.size(), 0);
        check({name, "_rd_left"}, exp_rd_q.size(), 0);
        check({name, "_rsp_left"}, exp_q.size(), 0);
    endtask

    // Directed sequence.
    initial begin
        int base;
        int n;
        bus.cmd_data   = 8'd0;
        bus.cmd_valid  = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.reg_datao  = 8'd0;
        bus.reg_hyplen = 16'd0;

        // Reset: outputs quiet, then ready in the first free cycle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);
        check("strobes_after_reset", {30'd0, bus.reg_read, bus.reg_write}, 32'd0);
        @(posedge clk);
        #1;

        // One-byte write to address 38.
        wd = {8'h5A};
        base = wr_seen;
        model_cmd(8'h26, 16'd1, 16'd0, 1);
        send_cmd(8'h26, 16'd1, 1);
        wait_idle("write1_idle");
        check("write1_count", wr_seen - base, 1);
        check("write1_literal", last_wr, {8'd38, 16'd0, 8'h5A});
        check_drained("write1");

        // Eight-byte read from address 55: latency and spacing.
        rd_cyc_q.delete();
        first_rsp_cyc = -1;
        model_cmd(8'hB7, 16'd8, 16'd0, 0);
        send_cmd(8'hB7, 16'd8, 0);
        base = last_xfer_cyc;
        wait_idle("read8_idle");
        check("read8_latency", first_rsp_cyc - base, 3);
        check("read8_count", rd_cyc_q.size(), 8);
        for (int i = 1; i < rd_cyc_q.size(); i++)
            check("read8_spacing", rd_cyc_q[i] - rd_cyc_q[i-1], 3);
        check_drained("read8");

        // Zero length falls back to reg_hyplen.
        bus.reg_hyplen = 16'd1;
        base = rd_seen;
        model_cmd(8'hA8, 16'd0, 16'd1, 0);
        send_cmd(8'hA8, 16'd0, 0);
        wait_idle("hyp1_idle");
        check("hyp1_size", {16'd0, last_size}, 32'd1);
        check("hyp1_reads", rd_seen - base, 1);
        check_drained("hyp1");
        bus.reg_hyplen = 16'd0;
        base = rd_seen;
        send_cmd(8'hA8, 16'd0, 0);
        @(negedge clk);
        check("hyp0_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("hyp0_reads", rd_seen - base, 0);

        // Backpressure: byte 0 held for 20 cycles, no timeout while stalled.
        bus.rsp_ready = 1'b0;
        rd_cyc_q.delete();
        rsp_cyc_q.delete();
        model_cmd(8'h85, 16'd2, 16'd0, 0);
        send_cmd(8'h85, 16'd2, 0);
        wait_rsp_valid("bp_valid");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid_hold", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_data_hold", {24'd0, bus.rsp_data}, 32'h10);
            check("bp_one_read", rd_cyc_q.size(), 1);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_idle("bp_idle");
        check("bp_reads", rd_cyc_q.size(), 2);
        if (rd_cyc_q.size() == 2 && rsp_cyc_q.size() >= 1)
            check("bp_second_read_after_xfer", rd_cyc_q[1], rsp_cyc_q[0] + 1);
        check_drained("bp");

        // Watchdog: 2-byte write, only one data byte arrives.
        wd = {8'h01};
        base = wr_seen;
        model_cmd(8'h26, 16'd2, 16'd0, 1);
        send_cmd(8'h26, 16'd2, 1);
        n = 0;
        @(negedge clk);
        n++;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        // One write-pulse cycle, then TIMEOUT silent cycles waiting for data.
        check("timeout_cycles", n, TIMEOUT + 2);
        check("timeout_writes", wr_seen - base, 1);
        @(posedge clk);
        #1;
        wd = {8'hC3};
        model_cmd(8'h0A, 16'd1, 16'd0, 1);
        send_cmd(8'h0A, 16'd1, 1);
        wait_idle("after_timeout_idle");
        check("after_timeout_write", last_wr, {8'd10, 16'd0, 8'hC3});
        check_drained("timeout");

        // Reset while a 4-byte read sits in RSEND (header bit6 set, ignored).
        bus.rsp_ready = 1'b0;
        model_cmd(8'hF1, 16'd4, 16'd0, 0);
        send_cmd(8'hF1, 16'd4, 0);
        wait_rsp_valid("rst_rsp_valid");
        check("rst_read_addr", 8'(bus.reg_address), 8'd49);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_rd_q.delete();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_mid_read");
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", {31'd0, bus.cmd_ready}, 32'd1);
        check("strobes_after_midreset", {30'd0, bus.reg_read, bus.reg_write}, 32'd0);
        @(posedge clk);
        #1;
        wd = {8'hA5};
        base = wr_seen;
        model_cmd(8'h3F, 16'd1, 16'd0, 1);
        send_cmd(8'h3F, 16'd1, 1);
        wait_idle("post_reset_idle");
        check("post_reset_writes", wr_seen - base, 1);
        check("post_reset_write", last_wr, {8'd63, 16'd0, 8'hA5});
        check_drained("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL global_timeout simulation exceeded 1000000 time units");
        $fatal(1, "global timeout");
    end
endmodule
